// File: rtl/afifo_pkg.sv
// Shared defaults and pointer-width helper for the single-clock FWFT FIFO.
package afifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;

    // Pointers carry one extra wrap bit above the address.
    function automatic int ptr_w(input int asize);
        return asize + 1;
    endfunction

endpackage

// File: rtl/afifo_mem.sv
// FIFO storage: 2**ASIZE x DSIZE, synchronous write, asynchronous read, no reset.
module afifo_mem
    import afifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/afifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// Define AFIFO_FILL_LEVEL_EN to add the registered o_fill occupancy port.
module afifo
    import afifo_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF,
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic [DSIZE-1:0] i_wdata,
    output logic             o_wfull,
    input  logic             i_rd,
    output logic [DSIZE-1:0] o_rdata,
`ifdef AFIFO_FILL_LEVEL_EN
    output logic [ASIZE:0]   o_fill,
`endif
    output logic             o_rempty
);

    localparam int PW = ptr_w(ASIZE);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          wfull_q, wfull_d;
    logic          rempty_q, rempty_d;
    logic          wr_ok, rd_ok;

    assign wr_ok = i_wr && !wfull_q;
    assign rd_ok = i_rd && !rempty_q;

    // Flags come from next-state pointers so they are valid the cycle after the edge.
    always_comb begin
        wptr_d   = wptr_q + PW'(wr_ok);
        rptr_d   = rptr_q + PW'(rd_ok);
        rempty_d = (wptr_d == rptr_d);
        wfull_d  = (wptr_d[PW-1] != rptr_d[PW-1]) &&
                   (wptr_d[PW-2:0] == rptr_d[PW-2:0]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            wfull_q  <= 1'b0;
            rempty_q <= 1'b1;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wfull_q  <= wfull_d;
            rempty_q <= rempty_d;
        end
    end

`ifdef AFIFO_FILL_LEVEL_EN
    logic [ASIZE:0] fill_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) fill_q <= '0;
        else          fill_q <= wptr_d - rptr_d;
    end

    assign o_fill = fill_q;
`endif

    afifo_mem #(
        .DSIZE(DSIZE),
        .ASIZE(ASIZE)
    ) u_mem (
        .i_clk  (i_clk),
        .i_we   (wr_ok),
        .i_waddr(wptr_q[PW-2:0]),
        .i_wdata(i_wdata),
        .i_raddr(rptr_q[PW-2:0]),
        .o_rdata(o_rdata)
    );

    assign o_wfull  = wfull_q;
    assign o_rempty = rempty_q;

endmodule

// File: tb/tb_afifo.sv
// Directed bench for afifo: reset, fill/drain, FWFT latency, random traffic,
// full with simultaneous read/write, and asynchronous reset mid-operation.
module tb_afifo;

    logic       clk;
    logic       rst_n;
    logic       wr;
    logic [7:0] wdata;
    logic       wfull;
    logic       rd;
    logic [7:0] rdata;
    logic       rempty;
`ifdef AFIFO_FILL_LEVEL_EN
    logic [4:0] fill;
`endif

    int checks = 0;
    int errors = 0;

    afifo #(.DSIZE(8), .ASIZE(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_wr    (wr),
        .i_wdata (wdata),
        .o_wfull (wfull),
        .i_rd    (rd),
        .o_rdata (rdata),
`ifdef AFIFO_FILL_LEVEL_EN
        .o_fill  (fill),
`endif
        .o_rempty(rempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        wdata = '0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    int wcnt, rcnt, occ;
    logic dw, dr;

    initial begin
        rst_n = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        wdata = '0;
        #12;
        chk("rst_empty_in", rempty, 1);
        chk("rst_full_in", wfull, 0);
        #5;
        rst_n = 1'b1;
        tick();
        tick();
        // 1. reset state after release, idle inputs
        chk("rst_empty", rempty, 1);
        chk("rst_full", wfull, 0);
`ifdef AFIFO_FILL_LEVEL_EN
        chk("rst_fill", fill, 0);
`endif

        // 2. fill 0x00..0x0F, overflow write ignored, drain in order
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1;
            wdata = 8'(i);
            tick();
            if (i == 14) chk("fill15_notfull", wfull, 0);
        end
        chk("fill16_full", wfull, 1);
        chk("fill16_notempty", rempty, 0);
`ifdef AFIFO_FILL_LEVEL_EN
        chk("fill16_fill", fill, 16);
`endif
        wdata = 8'hAA;
        tick();
        wr = 1'b0;
        chk("ovf_full", wfull, 1);
        chk("ovf_head", rdata, 8'h00);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_data%0d", i), rdata, 32'(i));
            chk($sformatf("drain_ne%0d", i), rempty, 0);
            rd = 1'b1;
            tick();
            if (i == 0) chk("drain_full_clr", wfull, 0);
        end
        rd = 1'b0;
        chk("drain_empty", rempty, 1);
        tick();
        chk("drain_stay_empty", rempty, 1);

        // 3. FWFT: written word visible on the next cycle without a read
        wr = 1'b1;
        wdata = 8'h5A;
        tick();
        wr = 1'b0;
        chk("fwft_ne", rempty, 0);
        chk("fwft_data", rdata, 8'h5A);
        tick();
        chk("fwft_hold", rdata, 8'h5A);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("fwft_empty", rempty, 1);
        // read while empty is ignored
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("rd_empty_ign", rempty, 1);
        wr = 1'b1;
        wdata = 8'h3C;
        tick();
        wr = 1'b0;
        chk("after_ign_data", rdata, 8'h3C);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        chk("after_ign_empty", rempty, 1);

        // 4. random traffic against an occupancy/counter model, wrapping many times
        do_reset();
        wcnt = 0;
        rcnt = 0;
        for (int c = 0; c < 4000; c++) begin
            occ = wcnt - rcnt;
            chk("rnd_empty", rempty, (occ == 0));
            chk("rnd_full", wfull, (occ == 16));
            dw = ($urandom_range(0, 3) == 0);
            dr = ($urandom_range(0, 3) == 0);
            wr = dw && (occ != 16);
            rd = dr && (occ != 0);
            wdata = 8'(wcnt);
            if (rd) chk("rnd_data", rdata, 32'(rcnt[7:0]));
            tick();
            if (wr) wcnt++;
            if (rd) rcnt++;
        end
        wr = 1'b0;
        rd = 1'b0;
        chk("rnd_traffic", (wcnt > 300) && (rcnt > 300), 1);

        // 5. full FIFO with simultaneous write+read: pop head, drop write
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1;
            wdata = 8'(8'h10 + i);
            tick();
        end
        chk("wr_rd_pre_full", wfull, 1);
        wr = 1'b1;
        rd = 1'b1;
        wdata = 8'hEE;
        tick();
        wr = 1'b0;
        rd = 1'b0;
        chk("wr_rd_full_clr", wfull, 0);
        chk("wr_rd_head", rdata, 8'h11);
`ifdef AFIFO_FILL_LEVEL_EN
        chk("wr_rd_fill", fill, 15);
`endif
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("wr_rd_drain%0d", i), rdata, 32'(8'h10 + i));
            rd = 1'b1;
            tick();
        end
        rd = 1'b0;
        chk("wr_rd_empty", rempty, 1);

        // simultaneous write+read at mid occupancy keeps flags
        wr = 1'b1;
        wdata = 8'h01;
        tick();
        wdata = 8'h02;
        rd = 1'b1;
        tick();
        wr = 1'b0;
        rd = 1'b0;
        chk("mid_wr_rd_ne", rempty, 0);
        chk("mid_wr_rd_data", rdata, 8'h02);

        // 6. five writes then asynchronous reset mid-cycle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr = 1'b1;
            wdata = 8'(8'h70 + i);
            tick();
        end
        wr = 1'b0;
        chk("arst_pre_ne", rempty, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_empty", rempty, 1);
        chk("arst_full", wfull, 0);
`ifdef AFIFO_FILL_LEVEL_EN
        chk("arst_fill", fill, 0);
`endif
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst_post_empty", rempty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
